pio_ctrl: RTL and testbench

Host-facing controller for a PIO block of 4 `machine` instances. It owns the single host register port and sequences every shared resource behind it:
- instruction memory write port
- per-machine enable, restart and clock divider settings
- TX/RX FIFO push/pop
- forced-instruction (imm) injection
- the shared 8-bit IRQ flag register

It sits between the bus adapter and the machine array.

---
 rtl/pio_pkg.sv | 55 +++++
 rtl/pio_irq_reg.sv | 22 ++
 rtl/pio_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pio_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO host controller: register map, FSM state
// encoding, reset defaults and the address decoder used by the controller.
package pio_pkg;

  localparam int          NUM_SM    = 4;
  localparam logic [23:0] DIV_RESET = 24'h000100;

  // Word addresses of the host register map.
  localparam logic [5:0] CTRL        = 6'h00;
  localparam logic [5:0] FSTAT       = 6'h01;
  localparam logic [5:0] IRQ         = 6'h02;
  localparam logic [5:0] IRQ_FORCE   = 6'h03;
  localparam logic [5:0] TXF_BASE    = 6'h04;
  localparam logic [5:0] RXF_BASE    = 6'h08;
  localparam logic [5:0] CLKDIV_BASE = 6'h0C;
  localparam logic [5:0] EXEC_BASE   = 6'h10;
  localparam logic [5:0] IMEM_BASE   = 6'h20;

  // Host transaction FSM: every access takes the same three-step path.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [3:0] {
    RGN_CTRL,
    RGN_FSTAT,
    RGN_IRQ,
    RGN_IRQ_FORCE,
    RGN_TXF,
    RGN_RXF,
    RGN_CLKDIV,
    RGN_EXEC,
    RGN_IMEM,
    RGN_NONE
  } region_e;

  // Map a word address onto the register region it hits. The four-entry
  // banks (TXF/RXF/CLKDIV/EXEC) are aligned, so addr[5:2] picks the bank
  // and addr[1:0] picks the machine.
  function automatic region_e decode_region(input logic [5:0] addr);
    region_e rgn;
    rgn = RGN_NONE;
    if ((addr & IMEM_BASE) != 6'd0)           rgn = RGN_IMEM;
    else if (addr == CTRL)                    rgn = RGN_CTRL;
    else if (addr == FSTAT)                   rgn = RGN_FSTAT;
    else if (addr == IRQ)                     rgn = RGN_IRQ;
    else if (addr == IRQ_FORCE)               rgn = RGN_IRQ_FORCE;
    else if (addr[5:2] == TXF_BASE[5:2])      rgn = RGN_TXF;
    else if (addr[5:2] == RXF_BASE[5:2])      rgn = RGN_RXF;
    else if (addr[5:2] == CLKDIV_BASE[5:2])   rgn = RGN_CLKDIV;
    else if (addr[5:2] == EXEC_BASE[5:2])     rgn = RGN_EXEC;
    return rgn;
  endfunction

endpackage

// File: rtl/pio_irq_reg.sv
// Flag register with set-over-clear priority. Used for the shared IRQ flags
// and for the sticky FIFO error bits: a set arriving in the same cycle as a
// clear of the same bit keeps the bit at 1.
module pio_irq_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] flags
);

  // Merge sets every cycle; a clear only takes effect on bits not being set.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    if (reset) flags <= '0;
    else       flags <= (flags | set) & ~(clr & ~set);
  end

endmodule

// File: rtl/pio_ctrl.sv
// Host-facing controller for a 4-machine PIO block. One host transaction is
// handled at a time: IDLE captures the request, ACCESS performs it (all side
// effect strobes fire here, for one cycle), RESP returns ack and read data.
module pio_ctrl #(
  parameter int          NUM_SM    = pio_pkg::NUM_SM,
  parameter logic [23:0] DIV_RESET = pio_pkg::DIV_RESET
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [5:0]             addr,
  input  logic [31:0]            wdata,
  output logic                   ack,
  output logic [31:0]            rdata,
  output logic [NUM_SM-1:0]      sm_en,
  output logic [NUM_SM-1:0]      sm_restart,
  output logic [24*NUM_SM-1:0]   sm_div,
  output logic [NUM_SM-1:0]      sm_imm,
  output logic [15:0]            imm_instr,
  output logic                   imem_we,
  output logic [4:0]             imem_waddr,
  output logic [15:0]            imem_wdata,
  output logic [NUM_SM-1:0]      tx_push,
  output logic [31:0]            tx_data,
  input  logic [NUM_SM-1:0]      tx_full,
  output logic [NUM_SM-1:0]      rx_pop,
  input  logic [32*NUM_SM-1:0]   rx_data,
  input  logic [NUM_SM-1:0]      rx_empty,
  input  logic [7:0]             irq_set,
  output logic [7:0]             irq_flags
);

  import pio_pkg::*;

  logic [1:0]               state_q;
  logic                     we_q;
  logic [5:0]               addr_q;
  logic [31:0]              wdata_q;
  logic [NUM_SM-1:0]        en_q;
  logic [NUM_SM-1:0][23:0]  div_q;
  logic [NUM_SM-1:0][31:0]  rx_heads;

  region_e                  rgn;
  logic [1:0]               idx;
  logic [NUM_SM-1:0]        sel;
  logic                     access;
  logic                     wr;
  logic                     rd;
  logic [31:0]              rd_val;

  logic [NUM_SM-1:0]        tx_hit;
  logic [NUM_SM-1:0]        rx_hit;
  logic [2*NUM_SM-1:0]      err_set;
  logic [2*NUM_SM-1:0]      err_clr;
  logic [2*NUM_SM-1:0]      err_flags;
  logic [7:0]               irq_clr;
  logic [7:0]               irq_force;
  logic [7:0]               irq_set_all;

  assign rx_heads = rx_data;
  assign sm_div   = div_q;
  assign rgn      = decode_region(addr_q);
  assign idx      = addr_q[1:0];

  // Strobes are suppressed while reset is asserted so an aborted access
  // leaves no side effects behind.
  assign access = (state_q == ST_ACCESS) && !reset;
  assign wr     = access && we_q;
  assign rd     = access && !we_q;

  // One-hot machine select for the banked registers.
  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

  // Transaction sequencer: capture the request in IDLE, then fixed
  // ACCESS and RESP steps; req is only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      // NOTE: the captured request is reset too, so the decoder never sees
      // X after reset even though it is only consumed in ACCESS.
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_ACCESS;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
        end
        ST_ACCESS: state_q <= ST_RESP;
        ST_RESP:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Completion: ack pulses in RESP, carrying the data captured in ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= (state_q == ST_ACCESS);
      if (state_q == ST_ACCESS) rdata <= we_q ? 32'd0 : rd_val;
    end
  end

  // Persistent machine configuration: enables and clock dividers.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q  <= '0;
      div_q <= {NUM_SM{DIV_RESET}};
    end else if (wr) begin
      case (rgn)
        RGN_CTRL:   en_q       <= wdata_q[NUM_SM-1:0];
        RGN_CLKDIV: div_q[idx] <= wdata_q[23:0];
        default: ;
      endcase
    end
  end

  // Side-effect strobes and their data, valid only in the ACCESS cycle.
  // A CTRL write shows its new enables in the same cycle as the restart
  // pulse, ahead of the register update at the end of ACCESS.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    sm_en      = en_q;
    sm_restart = '0;
    sm_imm     = '0;
    imm_instr  = '0;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    tx_push    = '0;
    tx_data    = '0;
    rx_pop     = '0;
    tx_hit     = '0;
    rx_hit     = '0;
    if (wr) begin
      case (rgn)
        RGN_CTRL: begin
          sm_en      = wdata_q[NUM_SM-1:0];
          sm_restart = wdata_q[NUM_SM+3:4];
        end
        RGN_TXF: begin
          tx_push = sel & ~tx_full;
          tx_hit  = sel & tx_full;
          tx_data = wdata_q;
        end
        RGN_EXEC: begin
          sm_imm    = sel;
          imm_instr = wdata_q[15:0];
        end
        RGN_IMEM: begin
          imem_we    = 1'b1;
          imem_waddr = addr_q[4:0];
          imem_wdata = wdata_q[15:0];
        end
        default: ;
      endcase
    end
    if (rd && (rgn == RGN_RXF)) begin
      rx_pop = sel & ~rx_empty;
      rx_hit = sel & rx_empty;
    end
  end

  // Read mux; write-only and unmapped locations read as zero, as does an
  // RX read from an empty FIFO.
  always_comb begin
    rd_val = '0;
    case (rgn)
      RGN_CTRL:   rd_val[NUM_SM-1:0]   = en_q;
      RGN_FSTAT:  rd_val[4*NUM_SM-1:0] = {err_flags, rx_empty, tx_full};
      RGN_IRQ:    rd_val[7:0]          = irq_flags;
      RGN_RXF:    if (!rx_empty[idx]) rd_val = rx_heads[idx];
      RGN_CLKDIV: rd_val[23:0]         = div_q[idx];
      default: ;
    endcase
  end

  // Host masks for the flag registers: W1C clears and forced IRQ sets.
  always_comb begin
    irq_clr   = '0;
    irq_force = '0;
    err_clr   = '0;
    if (wr) begin
      case (rgn)
        RGN_IRQ:       irq_clr   = wdata_q[7:0];
        RGN_IRQ_FORCE: irq_force = wdata_q[7:0];
        RGN_FSTAT:     err_clr   = wdata_q[4*NUM_SM-1:2*NUM_SM];
        default: ;
      endcase
    end
  end

  assign irq_set_all = irq_set | irq_force;
  assign err_set     = {rx_hit, tx_hit};

  pio_irq_reg #(.WIDTH(8)) u_irq (
    .clk   (clk),
    .reset (reset),
    .set   (irq_set_all),
    .clr   (irq_clr),
    .flags (irq_flags)
  );

  // Sticky errors: [NUM_SM-1:0] TX overflow, [2*NUM_SM-1:NUM_SM] RX underflow.
  pio_irq_reg #(.WIDTH(2*NUM_SM)) u_err (
    .clk   (clk),
    .reset (reset),
    .set   (err_set),
    .clr   (err_clr),
    .flags (err_flags)
  );

endmodule

// File: tb/tb_pio_ctrl.sv
// Self-checking bench for pio_ctrl. A transaction-level model tracks the
// register state; a compare process checks every output each cycle, and
// directed steps pin the model with hand-computed values.
module tb_pio_ctrl;

  localparam logic [23:0] DIV_RST = 24'h000100;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [5:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic         ack;
  logic [31:0]  rdata;
  logic [3:0]   sm_en, sm_restart, sm_imm, tx_push, rx_pop;
  logic [95:0]  sm_div;
  logic [15:0]  imm_instr, imem_wdata;
  logic         imem_we;
  logic [4:0]   imem_waddr;
  logic [31:0]  tx_data;
  logic [3:0]   tx_full = 4'h0;
  logic [127:0] rx_data = '0;
  logic [3:0]   rx_empty = 4'hF;
  logic [7:0]   irq_set = 8'h00;
  logic [7:0]   irq_flags;

  pio_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .sm_en(sm_en), .sm_restart(sm_restart),
    .sm_div(sm_div), .sm_imm(sm_imm), .imm_instr(imm_instr),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty),
    .irq_set(irq_set), .irq_flags(irq_flags)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  logic [3:0]        m_en = 4'h0;
  logic [3:0][23:0]  m_div = {4{DIV_RST}};
  logic [3:0]        m_txover = 4'h0;
  logic [3:0]        m_rxunder = 4'h0;
  logic [7:0]        m_irq = 8'h00;
  logic              div_pend = 1'b0;
  int                div_idx = 0;
  logic [23:0]       div_val = '0;

  // Expected per-cycle outputs.
  logic        ex_ack = 1'b0, ex_rd_valid = 1'b0;
  logic [31:0] ex_rdata = '0, ex_tx_data = '0;
  logic [3:0]  ex_restart = '0, ex_imm = '0, ex_push = '0, ex_pop = '0;
  logic [15:0] ex_imm_instr = '0, ex_iwdata = '0;
  logic        ex_imem_we = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [7:0]  ex_force = '0, ex_clear = '0;

  typedef struct packed {
    logic [3:0]  restart;
    logic [3:0]  en;
    logic [3:0]  push;
    logic [3:0]  pop;
    logic [3:0]  imm;
    logic [15:0] imm_instr;
    logic        imem_we;
    logic [4:0]  waddr;
    logic [15:0] iwdata;
    logic [31:0] tx_data;
  } acc_t;

  // Flag rule: a bit being set this cycle ends at 1; otherwise a host
  // clear drops it; otherwise it holds.
  function automatic logic [7:0] irq_next(input logic [7:0] cur, input logic [7:0] set,
                                          input logic [7:0] clr);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      if (set[b])      r[b] = 1'b1;
      else if (clr[b]) r[b] = 1'b0;
      else             r[b] = cur[b];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) m_irq <= 8'h00;
    else       m_irq <= irq_next(m_irq, irq_set | ex_force, ex_clear);
  end

  task automatic clear_exp();
    ex_ack = 0; ex_rd_valid = 0; ex_restart = 0; ex_imm = 0; ex_push = 0;
    ex_pop = 0; ex_imem_we = 0; ex_force = 0; ex_clear = 0;
  endtask

  task automatic model_reset();
    m_en = 0; m_div = {4{DIV_RST}}; m_txover = 0; m_rxunder = 0; div_pend = 0;
    clear_exp();
  endtask

  // Effects of one host access, from the register map.
  task automatic model_access(input logic w, input logic [5:0] a, input logic [31:0] d);
    int n;
    n = int'(a[1:0]);
    ex_rdata = 32'd0;
    if (w) begin
      if (a == 6'h00) begin m_en = d[3:0]; ex_restart = d[7:4]; end
      else if (a == 6'h01) begin m_txover &= ~d[11:8]; m_rxunder &= ~d[15:12]; end
      else if (a == 6'h02) ex_clear = d[7:0];
      else if (a == 6'h03) ex_force = d[7:0];
      else if (a >= 6'h04 && a <= 6'h07) begin
        if (tx_full[n]) m_txover[n] = 1'b1;
        else begin ex_push[n] = 1'b1; ex_tx_data = d; end
      end
      else if (a >= 6'h0C && a <= 6'h0F) begin div_pend = 1; div_idx = n; div_val = d[23:0]; end
      else if (a >= 6'h10 && a <= 6'h13) begin ex_imm[n] = 1'b1; ex_imm_instr = d[15:0]; end
      else if (a >= 6'h20) begin ex_imem_we = 1; ex_waddr = a[4:0]; ex_iwdata = d[15:0]; end
    end else begin
      if (a == 6'h00) ex_rdata = {28'd0, m_en};
      else if (a == 6'h01) ex_rdata = {16'd0, m_rxunder, m_txover, rx_empty, tx_full};
      else if (a == 6'h02) ex_rdata = {24'd0, m_irq};
      else if (a >= 6'h08 && a <= 6'h0B) begin
        if (rx_empty[n]) m_rxunder[n] = 1'b1;
        else begin ex_pop[n] = 1'b1; ex_rdata = rx_data[n*32 +: 32]; end
      end
      else if (a >= 6'h0C && a <= 6'h0F) ex_rdata = {8'd0, m_div[n]};
    end
  endtask

  task automatic model_resp(input logic w);
    clear_exp();
    ex_ack = 1; ex_rd_valid = !w;
    if (div_pend) begin m_div[div_idx] = div_val; div_pend = 0; end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One host access; returns the acked rdata and a snapshot of the strobes
  // seen in the access cycle. ack must appear exactly two cycles after the
  // cycle in which req is presented.
  task automatic do_txn(input logic w, input logic [5:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output acc_t acc);
    logic [2:0] ack_hist;
    step(); req = 1; we = w; addr = a; wdata = d; clear_exp();
    @(negedge clk); ack_hist[0] = ack;
    step(); model_access(w, a, d);
    @(negedge clk); ack_hist[1] = ack;
    acc.restart = sm_restart; acc.en = sm_en; acc.push = tx_push; acc.pop = rx_pop;
    acc.imm = sm_imm; acc.imm_instr = imm_instr; acc.imem_we = imem_we;
    acc.waddr = imem_waddr; acc.iwdata = imem_wdata; acc.tx_data = tx_data;
    step(); req = 0; model_resp(w);
    @(negedge clk); ack_hist[2] = ack; rd = rdata;
    step(); clear_exp();
    check($sformatf("ack_latency@%0h", a), ack_hist, 3'b100);
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("ack", ack, ex_ack);
        if (ex_ack && ex_rd_valid) check("rdata", rdata, ex_rdata);
        check("sm_en", sm_en, m_en);
        check("sm_div", sm_div, m_div);
        check("sm_restart", sm_restart, ex_restart);
        check("sm_imm", sm_imm, ex_imm);
        if (ex_imm != 4'h0) check("imm_instr", imm_instr, ex_imm_instr);
        check("imem_we", imem_we, ex_imem_we);
        if (ex_imem_we) begin
          check("imem_waddr", imem_waddr, ex_waddr);
          check("imem_wdata", imem_wdata, ex_iwdata);
        end
        check("tx_push", tx_push, ex_push);
        if (ex_push != 4'h0) check("tx_data", tx_data, ex_tx_data);
        check("rx_pop", rx_pop, ex_pop);
        check("irq_flags", irq_flags, m_irq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    acc_t acc;
    model_reset();
    step(); step(); reset = 0;

    // Reset state.
    @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_sm_div", sm_div, {4{24'h000100}});
    check("rst_irq", irq_flags, 8'h00);

    do_txn(0, 6'h0C, 0, rd, acc); check("rd_clkdiv0_rst", rd, 32'h00000100);
    do_txn(0, 6'h00, 0, rd, acc); check("rd_ctrl_rst", rd, 32'h0);

    // Enable + restart in one write.
    do_txn(1, 6'h00, 32'h000000A5, rd, acc);
    check("ctrl_restart", acc.restart, 4'hA);
    check("ctrl_en_in_access", acc.en, 4'h5);
    do_txn(0, 6'h00, 0, rd, acc); check("rd_ctrl", rd, 32'h5);

    // TX overflow, W1C, then a normal push.
    step(); tx_full = 4'b0100;
    do_txn(1, 6'h06, 32'hDEADBEEF, rd, acc); check("txover_no_push", acc.push, 4'h0);
    do_txn(0, 6'h01, 0, rd, acc); check("fstat_txover", rd, 32'h000004F4);
    do_txn(1, 6'h01, 32'h400, rd, acc);
    do_txn(0, 6'h01, 0, rd, acc); check("fstat_w1c", rd, 32'h000000F4);
    step(); tx_full = 4'b0000;
    do_txn(1, 6'h04, 32'h12, rd, acc);
    check("tx_push0", acc.push, 4'b0001);
    check("tx_data0", acc.tx_data, 32'h12);

    // RX pop and underflow.
    step(); rx_empty = 4'b1101; rx_data[63:32] = 32'hCAFEF00D;
    do_txn(0, 6'h09, 0, rd, acc);
    check("rx1_data", rd, 32'hCAFEF00D);
    check("rx1_pop", acc.pop, 4'b0010);
    do_txn(0, 6'h08, 0, rd, acc);
    check("rx0_empty_data", rd, 32'h0);
    check("rx0_empty_pop", acc.pop, 4'h0);
    do_txn(0, 6'h01, 0, rd, acc); check("fstat_rxunder", rd, 32'h000010D0);

    // Forced instructions (also to a disabled machine) and IMEM write.
    do_txn(1, 6'h12, 32'h0000E081, rd, acc);
    check("exec2_imm", acc.imm, 4'b0100);
    check("exec2_instr", acc.imm_instr, 16'hE081);
    do_txn(1, 6'h11, 32'h0000A0A0, rd, acc);
    check("exec1_imm_disabled", acc.imm, 4'b0010);
    do_txn(1, 6'h3F, 32'h00001234, rd, acc);
    check("imem_we", acc.imem_we, 1'b1);
    check("imem_waddr", acc.waddr, 5'd31);
    check("imem_wdata", acc.iwdata, 16'h1234);

    // Clock divider write/readback, upper byte dropped.
    do_txn(1, 6'h0D, 32'hFFABCDEF, rd, acc);
    do_txn(0, 6'h0D, 0, rd, acc); check("rd_clkdiv1", rd, 32'h00ABCDEF);
    check("sm_div1", sm_div[47:24], 24'hABCDEF);

    // Unmapped and write-only locations.
    do_txn(1, 6'h15, 32'hFFFFFFFF, rd, acc);
    do_txn(0, 6'h15, 0, rd, acc); check("rd_unmapped", rd, 32'h0);
    do_txn(0, 6'h04, 0, rd, acc); check("rd_txf_wo", rd, 32'h0);

    // IRQ: set beats clear, then force.
    irq_set = 8'h03; step(); irq_set = 8'h00;
    @(negedge clk); check("irq_set03", irq_flags, 8'h03);
    irq_set = 8'h01;
    do_txn(1, 6'h02, 32'h03, rd, acc);
    irq_set = 8'h00;
    @(negedge clk); check("irq_set_wins", irq_flags, 8'h01);
    do_txn(1, 6'h03, 32'h80, rd, acc);
    @(negedge clk); check("irq_force", irq_flags, 8'h81);
    do_txn(0, 6'h02, 0, rd, acc); check("rd_irq", rd, 32'h81);

    // Reset in the middle of a CTRL write aborts it with no ack.
    step(); req = 1; we = 1; addr = 6'h00; wdata = 32'h000000FF; clear_exp();
    step(); reset = 1;
    step(); reset = 0; req = 0; model_reset();
    @(negedge clk);
    check("abort_ack", ack, 1'b0);
    check("abort_sm_en", sm_en, 4'h0);
    check("abort_irq", irq_flags, 8'h00);
    check("abort_div", sm_div, {4{24'h000100}});
    step();
    @(negedge clk); check("abort_ack_late", ack, 1'b0);
    do_txn(0, 6'h00, 0, rd, acc); check("rd_ctrl_after_abort", rd, 32'h0);
    do_txn(0, 6'h0D, 0, rd, acc); check("rd_clkdiv1_after_abort", rd, 32'h00000100);

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
